// File: rtl/soc.sv
// soc - processing-in-memory compute top.
//
// A 16 x 32-bit on-chip memory feeds a sequencer that repeatedly computes
// rotated dot products  acc = sum_i mem[i] * mem[(i+p) mod 16],
// writes each result back into mem[p] and publishes it on GPIO.
// A single busy input freezes every register for as long as it is high.
//
// Ports:
//   clk   - system clock, rising edge
//   rstN  - asynchronous active-low reset (also re-initialises memory)
//   busy  - synchronous stall request; all state holds while 1
//   GPIO  - registered 32-bit result port
//
// Build option:
//   SOC_GPIO_TAG_EN - when defined, GPIO = {tag[7:0], acc[23:0]} with an
//                     8-bit pass tag; when undefined, GPIO = acc and no tag
//                     register exists.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | one cycle after reset, clears index/accumulator
// MAC    | one multiply-accumulate per cycle, i = 0..15
// DONE   | write back mem[p], publish GPIO, advance p (and tag)

module soc (
  input  logic        clk,
  input  logic        rstN,
  input  logic        busy,
  output logic [31:0] GPIO
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_mem [16];
  logic [3:0]  r_p;
  logic [3:0]  r_i;
  logic [31:0] r_acc;
  logic [31:0] r_gpio;

  logic [3:0]  w_idx_b;
  logic [31:0] w_prod;
  logic [31:0] w_gpio_next;

  // 4-bit add wraps naturally, giving the (i+p) mod 16 rotation.
  assign w_idx_b = r_i + r_p;
  assign w_prod  = r_mem[r_i] * r_mem[w_idx_b];

  always_comb begin
    w_state_next = r_state;
    if (!busy) begin
      case (r_state)
        S_IDLE:  w_state_next = S_MAC;
        S_MAC:   w_state_next = (r_i == 4'd15) ? S_DONE : S_MAC;
        S_DONE:  w_state_next = S_MAC;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

`ifdef SOC_GPIO_TAG_EN
  logic [7:0] r_tag;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_tag <= 8'd0;
    end else if (!busy && r_state == S_DONE) begin
      r_tag <= r_tag + 8'd1;
    end
  end

  // Tag published is the pre-increment value, so pass 0 carries tag 0.
  assign w_gpio_next = {r_tag, r_acc[23:0]};
`else
  assign w_gpio_next = r_acc;
`endif

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int k = 0; k < 16; k++) begin
        r_mem[k] <= 32'(k + 1);
      end
      r_p    <= 4'd0;
      r_i    <= 4'd0;
      r_acc  <= 32'd0;
      r_gpio <= 32'd0;
    end else if (!busy) begin
      case (r_state)
        S_IDLE: begin
          r_i   <= 4'd0;
          r_acc <= 32'd0;
        end
        S_MAC: begin
          r_acc <= r_acc + w_prod;
          r_i   <= r_i + 4'd1;
        end
        S_DONE: begin
          r_mem[r_p] <= r_acc;
          r_gpio     <= w_gpio_next;
          r_p        <= r_p + 4'd1;
          r_i        <= 4'd0;
          r_acc      <= 32'd0;
        end
        default: begin
        end
      endcase
    end
  end

  assign GPIO = r_gpio;

endmodule

// File: tb/tb_soc.sv
module tb_soc;

  logic        clk;
  logic        rstN;
  logic        busy;
  logic [31:0] GPIO;

  int n_pass;
  int n_total;

  // Reference model: memory image, pass counter, tag, unstalled edge count.
  logic [31:0] ref_mem [16];
  int          ref_p;
  logic [7:0]  ref_tag;
  int          ref_edges;
  int          ref_results;
  logic [31:0] exp_gpio;

`ifdef SOC_GPIO_TAG_EN
  localparam logic [31:0] FIRST_RESULT  = 32'h0000_05D8;
  localparam logic [31:0] SECOND_RESULT = 32'h0100_6E7E;
`else
  localparam logic [31:0] FIRST_RESULT  = 32'd1496;
  localparam logic [31:0] SECOND_RESULT = 32'd28286;
`endif

  soc dut (
    .clk  (clk),
    .rstN (rstN),
    .busy (busy),
    .GPIO (GPIO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k < 16; k++) ref_mem[k] = 32'(k + 1);
    ref_p       = 0;
    ref_tag     = 8'd0;
    ref_edges   = 0;
    ref_results = 0;
    exp_gpio    = 32'd0;
  endtask

  // One full pass computed directly from the definition of the operation.
  task automatic model_pass();
    logic [31:0] acc;
    acc = 32'd0;
    for (int k = 0; k < 16; k++) begin
      acc = acc + ref_mem[k] * ref_mem[(k + ref_p) % 16];
    end
    ref_mem[ref_p] = acc;
`ifdef SOC_GPIO_TAG_EN
    exp_gpio = {ref_tag, acc[23:0]};
`else
    exp_gpio = acc;
`endif
    ref_p       = (ref_p + 1) % 16;
    ref_tag     = ref_tag + 8'd1;
    ref_results = ref_results + 1;
  endtask

  // Drive busy for one rising edge, advance the model, return at edge+1.
  task automatic tick(input logic b);
    busy = b;
    @(posedge clk);
    if (!b && rstN) begin
      ref_edges = ref_edges + 1;
      if (ref_edges >= 18 && ((ref_edges - 18) % 17) == 0) model_pass();
    end
    #1;
  endtask

  task automatic apply_reset();
    #2;
    rstN = 1'b0;
    busy = 1'($urandom_range(1));
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    busy = 1'b1;
    #3;
    n_total++;
    if (GPIO !== 32'd0) $display("FAIL reset_gpio: got %h want %h", GPIO, 32'd0);
    else n_pass++;
    apply_reset();
    n_total++;
    if (GPIO !== 32'd0) $display("FAIL reset_release_gpio: got %h want %h", GPIO, 32'd0);
    else n_pass++;
  endtask

  task automatic test_first_results();
    apply_reset();
    repeat (17) tick(1'b0);
    n_total++;
    if (GPIO !== 32'd0) $display("FAIL before_first_result: got %h want %h", GPIO, 32'd0);
    else n_pass++;
    tick(1'b0);
    n_total++;
    if (GPIO !== FIRST_RESULT) $display("FAIL first_result: got %h want %h", GPIO, FIRST_RESULT);
    else n_pass++;
    n_total++;
    if (GPIO !== exp_gpio) $display("FAIL first_result_model: got %h want %h", GPIO, exp_gpio);
    else n_pass++;
    repeat (16) begin
      tick(1'b0);
      n_total++;
      if (GPIO !== FIRST_RESULT) $display("FAIL gpio_hold_pass1: got %h want %h", GPIO, FIRST_RESULT);
      else n_pass++;
    end
    tick(1'b0);
    n_total++;
    if (GPIO !== SECOND_RESULT) $display("FAIL second_result: got %h want %h", GPIO, SECOND_RESULT);
    else n_pass++;
    n_total++;
    if (GPIO !== exp_gpio) $display("FAIL second_result_model: got %h want %h", GPIO, exp_gpio);
    else n_pass++;
  endtask

  task automatic test_stall_done();
    apply_reset();
    repeat (17) tick(1'b0);
    repeat (7) begin
      tick(1'b1);
      n_total++;
      if (GPIO !== 32'd0) $display("FAIL stall_done_hold: got %h want %h", GPIO, 32'd0);
      else n_pass++;
    end
    tick(1'b0);
    n_total++;
    if (GPIO !== FIRST_RESULT) $display("FAIL stall_done_release: got %h want %h", GPIO, FIRST_RESULT);
    else n_pass++;
  endtask

  task automatic test_random_busy();
    logic b;
    int   len;
    apply_reset();
    for (int seg = 0; seg < 120; seg++) begin
      b   = ($urandom_range(99) < 30);
      len = $urandom_range(10, 5);
      for (int c = 0; c < len; c++) begin
        tick(b);
        n_total++;
        if (GPIO !== exp_gpio)
          $display("FAIL random_busy seg %0d edges %0d: got %h want %h", seg, ref_edges, GPIO, exp_gpio);
        else n_pass++;
      end
    end
    n_total++;
    if (ref_results < 3) $display("FAIL random_busy_progress: got %0d results want >= 3", ref_results);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    apply_reset();
    repeat (18 + 6) tick(1'b0);
    n_total++;
    if (GPIO !== FIRST_RESULT) $display("FAIL pre_reset_gpio: got %h want %h", GPIO, FIRST_RESULT);
    else n_pass++;
    #2;
    rstN = 1'b0;
    #1;
    n_total++;
    if (GPIO !== 32'd0) $display("FAIL async_reset_gpio: got %h want %h", GPIO, 32'd0);
    else n_pass++;
    busy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rstN = 1'b1;
    model_reset();
    repeat (17) tick(1'b0);
    n_total++;
    if (GPIO !== 32'd0) $display("FAIL post_reset_early: got %h want %h", GPIO, 32'd0);
    else n_pass++;
    tick(1'b0);
    n_total++;
    if (GPIO !== FIRST_RESULT) $display("FAIL post_reset_first: got %h want %h", GPIO, FIRST_RESULT);
    else n_pass++;
  endtask

  task automatic test_wrap();
    apply_reset();
    repeat (18 + 16 * 17) begin
      tick(1'b0);
      n_total++;
      if (GPIO !== exp_gpio)
        $display("FAIL wrap_run edges %0d: got %h want %h", ref_edges, GPIO, exp_gpio);
      else n_pass++;
    end
    n_total++;
    if (ref_results != 17) $display("FAIL wrap_result_count: got %0d want %0d", ref_results, 17);
    else n_pass++;
`ifdef SOC_GPIO_TAG_EN
    n_total++;
    if (GPIO[31:24] !== 8'd16) $display("FAIL wrap_tag: got %0d want %0d", GPIO[31:24], 16);
    else n_pass++;
`endif
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rstN    = 1'b0;
    busy    = 1'b0;
    model_reset();
    test_reset();
    test_first_results();
    test_stall_done();
    test_random_busy();
    test_async_reset();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/soc.md
# soc

Self-contained processing-in-memory compute top. It holds a small on-chip data memory and a sequencer that repeatedly computes rotated dot products over that memory, writes each result back into memory, and publishes it on a 32-bit GPIO output. A single `busy` input from the surrounding system stalls the whole block cycle-by-cycle. The bench drives this top directly, with no bus interface.

## Interface
- No parameters. Depth is fixed at 16 words and data width at 32 bits.
- `clk` — input, 1 bit. Single clock, rising edge.
- `rstN` — input, 1 bit. Reset, asynchronous and active-low.
- `busy` — input, 1 bit. Stall request. While it is 1, no state changes.
- `GPIO` — output, 32 bits. Registered result port.

## Operation
- Data memory `mem[0..15]` is 32-bit registers.
  - Asynchronous reset loads `mem[i] = i+1`.
  - No external load path exists.
- Registers:
  - pass counter `p` (4-bit, wraps 15→0)
  - element index `i` (4-bit)
  - accumulator `acc` (32-bit)
  - tag counter `tag` (8-bit, wraps 255→0)
  - GPIO register
- The FSM has three states: IDLE, MAC, DONE.
- Reset state:
  - FSM in IDLE.
  - `p=0`, `i=0`, `acc=0`, `tag=0`, `GPIO=32'h0`.
- IDLE → MAC, with `i=0` and `acc=0`.
- MAC:
  - Each cycle: `acc <= acc + mem[i]*mem[(i+p) mod 16]`.
  - Product and sum keep the low 32 bits and wrap silently.
  - `i` increments each cycle. After processing `i=15`, go to DONE.
- DONE, all in one edge:
  - `mem[p] <= acc`.
  - Publish `acc` on GPIO (format per Configuration).
  - `p <= p+1`, `tag <= tag+1`, `i <= 0`, `acc <= 0`.
  - Go to MAC. IDLE is re-entered only through reset.
- The memory write in DONE is visible to the next pass's first MAC read.

## Timing
- Stall: with `busy=1` at a rising edge, every register holds (FSM, `i`, `p`, `acc`, `tag`, `mem`, `GPIO`).
  - Stall length is unbounded.
  - Stalling in any state, including DONE, only delays that state.
- Counting only edges with `busy=0` and `rstN=1`:
  - First result appears on GPIO after 18 edges (1 IDLE + 16 MAC + 1 DONE).
  - Each later result appears 17 edges after the previous one.
- GPIO changes only on the DONE edge and stays stable otherwise.
- `rstN` low at any time, mid-pass or mid-stall:
  - Immediately forces the reset values above, including the memory re-init.
  - The first post-reset result again takes 18 unstalled edges.
- `busy` is sampled synchronously. Its value during reset is irrelevant.

## Configuration
- Macro `SOC_GPIO_TAG_EN`.
- Defined: `GPIO = {tag[7:0], acc[23:0]}`, where `tag` is the value before the DONE increment. So pass 0 carries tag 0.
- Undefined: `GPIO = acc[31:0]`, and `tag` logic is omitted.

## Test plan
- Reset, then `busy=0` throughout. After 18 edges: `GPIO = 32'd1496` (`0x5D8`), and `0x000005D8` with the tag macro. Before that edge, `GPIO = 0`.
- Continue unstalled. 17 edges later: `GPIO = 32'd28286` (`0x6E7E`; `0x01006E7E` with the tag macro). This confirms the `mem[0]` writeback.
- Apply `busy=1` for 7 cycles at the DONE cycle of pass 0:
  - GPIO stays 0 for the stall.
  - 1496 appears on the first unstalled edge afterwards.
- Apply 30% random `busy` with 5–10 cycle holds:
  - The sequence of GPIO values matches the unstalled run exactly.
  - Each GPIO change coincides with 17 unstalled edges since the previous change.
- Drop `rstN` during pass 1 MAC:
  - GPIO reads 0 asynchronously.
  - After release, the first result is 1496 again, proving the memory re-init.
- Run 16 passes unstalled:
  - `p` wraps back to 0.
  - The tag byte increments by 1 per result and keeps counting past 15 (for example `tag=16` on pass 16).
